// File: rtl/aes_sched_pkg.sv
// Shared types and sizes for the AES block scheduler.
package aes_sched_pkg;

  localparam int unsigned BLOCK_BYTES = 16;
  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned BLOCK_W     = 128;
  localparam int unsigned SLOT_W      = $clog2(BLOCK_BYTES + 1);

  // Index BLOCK_BYTES-1 is the most significant byte (first byte popped).
  typedef logic [BLOCK_BYTES-1:0][BYTE_W-1:0] block_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GATHER,
    S_LAUNCH,
    S_WAIT_AES,
    S_HOLD,
    S_EMIT,
    S_ERROR
  } sched_state_t;

endpackage

// File: rtl/aes_block_gather.sv
// Byte-slot assembly register for one 128-bit block, MSB-first.
module aes_block_gather
  import aes_sched_pkg::*;
(
  input  logic               clk,
  input  logic               n_rst,
  input  logic               push_i,
  input  logic [BYTE_W-1:0]  byte_i,
  input  logic               clear_i,
  input  logic               pad_i,
  output logic [BLOCK_W-1:0] data_o,
  output logic [SLOT_W-1:0]  count_o,
  output logic               full16_o
);

  block_t              slot_q, slot_d;
  logic [SLOT_W-1:0]   count_q, count_d;

  assign full16_o = (count_q == SLOT_W'(BLOCK_BYTES));
  assign data_o   = slot_q;
  assign count_o  = count_q;

  always_comb begin
    slot_d  = slot_q;
    count_d = count_q;
    if (clear_i) begin
      slot_d  = '0;
      count_d = '0;
    end else if (pad_i) begin
      for (int unsigned i = 0; i < BLOCK_BYTES; i++) begin
        if (SLOT_W'(i) >= count_q) slot_d[BLOCK_BYTES-1-i] = '0;
      end
      count_d = SLOT_W'(BLOCK_BYTES);
    end else if (push_i && !full16_o) begin
      for (int unsigned i = 0; i < BLOCK_BYTES; i++) begin
        if (SLOT_W'(i) == count_q) slot_d[BLOCK_BYTES-1-i] = byte_i;
      end
      count_d = count_q + SLOT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      slot_q  <= '0;
      count_q <= '0;
    end else begin
      slot_q  <= slot_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/aes_block_scheduler.sv
// Plaintext FIFO -> AES core -> output FIFO block sequencer.
// AES_SCHED_PAD_EN: an honored flush zero-pads and encrypts the partial block instead of discarding it.
module aes_block_scheduler
  import aes_sched_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 16
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               in_empty,
  input  logic [BYTE_W-1:0]  in_r_data,
  output logic               in_r_enable,
  input  logic               flush,
  output logic               aes_start,
  output logic [BLOCK_W-1:0] aes_plaintext,
  input  logic               aes_done,
  input  logic [BLOCK_W-1:0] aes_ciphertext,
  input  logic               out_ready,
  output logic               out_complete,
  output logic [BLOCK_W-1:0] out_block,
  output logic               busy,
  output logic               error,
  output logic [CNT_W-1:0]   blocks_done
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  sched_state_t        state_q, state_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic [BLOCK_W-1:0]  res_q, res_d;
  logic [CNT_W-1:0]    done_q, done_d;

  logic                push, g_clear, g_pad, full16, flush_ok;
  logic [SLOT_W-1:0]   gather_cnt;
  logic [BLOCK_W-1:0]  gather_data;

  aes_block_gather u_gather (
    .clk      (clk),
    .n_rst    (n_rst),
    .push_i   (push),
    .byte_i   (in_r_data),
    .clear_i  (g_clear),
    .pad_i    (g_pad),
    .data_o   (gather_data),
    .count_o  (gather_cnt),
    .full16_o (full16)
  );

  always_comb begin
    state_d      = state_q;
    tmr_d        = tmr_q;
    res_d        = res_q;
    done_d       = done_q;
    push         = 1'b0;
    g_clear      = 1'b0;
    g_pad        = 1'b0;
    flush_ok     = 1'b0;
    in_r_enable  = 1'b0;
    aes_start    = 1'b0;
    out_complete = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!in_empty) state_d = S_GATHER;
      end
      S_GATHER: begin
        in_r_enable = !in_empty && !full16;
        push        = in_r_enable;
        flush_ok    = in_empty && flush && (gather_cnt != '0) && !full16;
        if (push && (gather_cnt == SLOT_W'(BLOCK_BYTES - 1))) begin
          state_d = S_LAUNCH;
        end else if (flush_ok) begin
`ifdef AES_SCHED_PAD_EN
          g_pad   = 1'b1;
          state_d = S_LAUNCH;
`else
          g_clear = 1'b1;
          state_d = S_IDLE;
`endif
        end
      end
      S_LAUNCH: begin
        aes_start = 1'b1;
        tmr_d     = '0;
        state_d   = S_WAIT_AES;
      end
      S_WAIT_AES: begin
        // tmr_d counts WAIT_AES cycles including this one; done on the timeout cycle still wins.
        tmr_d = tmr_q + TMR_W'(1);
        if (aes_done) begin
          res_d   = aes_ciphertext;
          state_d = S_HOLD;
        end else if (tmr_d == TMR_W'(TIMEOUT_CYCLES)) begin
          state_d = S_ERROR;
        end
      end
      S_HOLD: begin
        if (out_ready) state_d = S_EMIT;
      end
      S_EMIT: begin
        out_complete = 1'b1;
        done_d       = done_q + CNT_W'(1);
        g_clear      = 1'b1;
        state_d      = in_empty ? S_IDLE : S_GATHER;
      end
      S_ERROR: begin
        state_d = S_ERROR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      res_q   <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      res_q   <= res_d;
      done_q  <= done_d;
    end
  end

  assign aes_plaintext = gather_data;
  assign out_block     = res_q;
  assign busy          = (state_q != S_IDLE);
  assign error         = (state_q == S_ERROR);
  assign blocks_done   = done_q;

endmodule

// File: tb/tb_aes_block_scheduler.sv
// Directed bench for aes_block_scheduler with a byte-FIFO and AES core model.
module tb_aes_block_scheduler;
  import aes_sched_pkg::*;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         in_empty;
  logic [7:0]   in_r_data;
  logic         in_r_enable;
  logic         flush;
  logic         aes_start;
  logic [127:0] aes_plaintext;
  logic         aes_done;
  logic [127:0] aes_ciphertext;
  logic         out_ready;
  logic         out_complete;
  logic [127:0] out_block;
  logic         busy;
  logic         error;
  logic [15:0]  blocks_done;

  aes_block_scheduler #(.TIMEOUT_CYCLES(64), .CNT_W(16)) dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .in_empty       (in_empty),
    .in_r_data      (in_r_data),
    .in_r_enable    (in_r_enable),
    .flush          (flush),
    .aes_start      (aes_start),
    .aes_plaintext  (aes_plaintext),
    .aes_done       (aes_done),
    .aes_ciphertext (aes_ciphertext),
    .out_ready      (out_ready),
    .out_complete   (out_complete),
    .out_block      (out_block),
    .busy           (busy),
    .error          (error),
    .blocks_done    (blocks_done)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  fifo[$];
  int          aes_cnt, aes_lat;
  bit          aes_on;
  logic [127:0] model_pt, launch_pt, last_blk;
  int          n_start, n_cmp, bad_pops, wait_cycles;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic refresh();
    in_empty  = (fifo.size() == 0);
    in_r_data = in_empty ? 8'h00 : fifo[0];
  endtask

  task automatic push_bytes(input logic [7:0] start, input int n);
    for (int i = 0; i < n; i++) fifo.push_back(start + 8'(i));
    refresh();
  endtask

  // One clock: sample just before the edge, let the edge happen, update models at the negedge.
  task automatic tick();
    bit pop, st;
    #1;
    pop = in_r_enable;
    st  = aes_start;
    if (in_r_enable && dut.state_q != S_GATHER) bad_pops++;
    if (dut.state_q == S_WAIT_AES) wait_cycles++;
    if (aes_start) begin n_start++; launch_pt = aes_plaintext; end
    if (out_complete) begin n_cmp++; last_blk = out_block; end
    @(posedge clk);
    if (pop && fifo.size() > 0) void'(fifo.pop_front());
    if (st) begin aes_cnt = aes_lat; model_pt = launch_pt; end
    @(negedge clk);
    aes_done = 1'b0;
    if (aes_on && aes_cnt > 0) begin
      aes_cnt--;
      if (aes_cnt == 0) begin
        aes_done       = 1'b1;
        aes_ciphertext = model_pt ^ {128{1'b1}};
      end
    end
    refresh();
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    fifo.delete();
    flush = 1'b0; out_ready = 1'b1; aes_done = 1'b0; aes_ciphertext = '0;
    aes_on = 1'b1; aes_lat = 10; aes_cnt = 0;
    n_start = 0; n_cmp = 0; bad_pops = 0; wait_cycles = 0;
    launch_pt = '0; last_blk = '0; model_pt = '0;
    refresh();
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
  endtask

  task automatic run_until_cmp(input string tag, input int n, input int bound);
    for (int i = 0; i < bound && n_cmp < n; i++) tick();
    chk(tag, 128'(n_cmp), 128'(n));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int hold_bad;
    do_reset();
    // Reset state
    #1;
    chk("rst_ren",   128'(in_r_enable), 128'(0));
    chk("rst_start", 128'(aes_start), 128'(0));
    chk("rst_cmp",   128'(out_complete), 128'(0));
    chk("rst_busy",  128'(busy), 128'(0));
    chk("rst_err",   128'(error), 128'(0));
    chk("rst_pt",    aes_plaintext, '0);
    chk("rst_blk",   out_block, '0);
    chk("rst_cnt",   128'(blocks_done), 128'(0));

    // Single block 00..0F
    @(negedge clk);
    push_bytes(8'h00, 16);
    run_until_cmp("t1_cmp", 1, 100);
    repeat (3) tick();
    chk("t1_pt",    launch_pt, 128'h000102030405060708090A0B0C0D0E0F);
    chk("t1_blk",   last_blk,  128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0);
    chk("t1_once",  128'(n_cmp), 128'(1));
    chk("t1_start", 128'(n_start), 128'(1));
    chk("t1_done",  128'(blocks_done), 128'(1));
    chk("t1_idle",  128'(busy), 128'(0));

    // Two blocks back to back
    do_reset();
    push_bytes(8'h20, 32);
    run_until_cmp("t2_cmp", 2, 200);
    chk("t2_start", 128'(n_start), 128'(2));
    chk("t2_pops",  128'(bad_pops), 128'(0));
    chk("t2_done",  128'(blocks_done), 128'(2));
    chk("t2_blk",   last_blk, 128'hCFCECDCCCBCAC9C8C7C6C5C4C3C2C1C0);

    // Output backpressure in HOLD
    do_reset();
    out_ready = 1'b0;
    push_bytes(8'h40, 16);
    push_bytes(8'h99, 1);
    for (int i = 0; i < 100 && dut.state_q != S_HOLD; i++) tick();
    chk("t3_hold", 128'(dut.state_q), 128'(S_HOLD));
    hold_bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      #1;
      if (dut.state_q != S_HOLD || out_block !== 128'hBFBEBDBCBBBAB9B8B7B6B5B4B3B2B1B0 ||
          in_r_enable !== 1'b0 || out_complete !== 1'b0) hold_bad++;
    end
    chk("t3_stable", 128'(hold_bad), 128'(0));
    chk("t3_fifo",   128'(fifo.size()), 128'(1));
    out_ready = 1'b1;
    #1;
    chk("t3_nofire", 128'(out_complete), 128'(0));
    tick();
    #1;
    chk("t3_fire",   128'(out_complete), 128'(1));
    chk("t3_blk",    out_block, 128'hBFBEBDBCBBBAB9B8B7B6B5B4B3B2B1B0);

    // Flush: ignored at count 0, honored after 5 bytes once FIFO drains
    do_reset();
    flush = 1'b1;
    repeat (3) tick();
    chk("t4_ign", 128'(dut.state_q), 128'(S_IDLE));
    push_bytes(8'hA1, 5);
    repeat (12) tick();
    chk("t4_drain", 128'(fifo.size()), 128'(0));
`ifdef AES_SCHED_PAD_EN
    chk("t4_pad_pt", launch_pt, {40'hA1A2A3A4A5, 88'h0});
    run_until_cmp("t4_pad_cmp", 1, 100);
    chk("t4_pad_done", 128'(blocks_done), 128'(1));
`else
    chk("t4_nostart", 128'(n_start), 128'(0));
    chk("t4_idle",    128'(dut.state_q), 128'(S_IDLE));
    chk("t4_cnt0",    128'(dut.gather_cnt), 128'(0));
    chk("t4_done",    128'(blocks_done), 128'(0));
`endif
    flush = 1'b0;

    // AES timeout -> sticky error
    do_reset();
    aes_on = 1'b0;
    push_bytes(8'h10, 19);
    for (int i = 0; i < 200 && error !== 1'b1; i++) tick();
    chk("t5_err",   128'(error), 128'(1));
    chk("t5_wait",  128'(wait_cycles), 128'(64));
    repeat (10) tick();
    chk("t5_nopop", 128'(fifo.size()), 128'(3));
    chk("t5_ren",   128'(in_r_enable), 128'(0));
    chk("t5_busy",  128'(busy), 128'(1));
    do_reset();
    #1;
    chk("t5_clr",   128'(error), 128'(0));
    chk("t5_idle",  128'(dut.state_q), 128'(S_IDLE));

    // aes_done on the exact timeout cycle wins
    @(negedge clk);
    aes_lat = 64;
    push_bytes(8'h70, 16);
    run_until_cmp("t6_cmp", 1, 200);
    chk("t6_noerr", 128'(error), 128'(0));
    chk("t6_wait",  128'(wait_cycles), 128'(64));

    // Reset mid-GATHER, then a fresh block
    do_reset();
    push_bytes(8'h50, 7);
    for (int i = 0; i < 20 && dut.gather_cnt != 5'd7; i++) tick();
    chk("t7_cnt7", 128'(dut.gather_cnt), 128'(7));
    n_rst = 1'b0;
    #1;
    chk("t7_busy", 128'(busy), 128'(0));
    chk("t7_cnt0", 128'(dut.gather_cnt), 128'(0));
    chk("t7_pt",   aes_plaintext, '0);
    do_reset();
    push_bytes(8'h60, 16);
    run_until_cmp("t7_cmp", 1, 100);
    chk("t7_fpt",  launch_pt, 128'h606162636465666768696A6B6C6D6E6F);
    chk("t7_blk",  last_blk,  128'h9F9E9D9C9B9A99989796959493929190);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_block_scheduler.md
# aes_block_scheduler

Sequencer between the plaintext byte FIFO, the shared AES core and the 128-bit-to-byte encrypted output FIFO. It collects 16 plaintext bytes and launches one AES operation. It then holds the ciphertext until the output side can accept a whole block, and hands it over with a single `complete` pulse. It enforces backpressure so that no ciphertext byte is ever dropped.

## Interface
- `TIMEOUT_CYCLES`, default 64: maximum number of WAIT_AES cycles before the error state is entered.
- `CNT_W`, default 16: width of the `blocks_done` counter.
- `clk` in 1: system clock.
- `n_rst` in 1: reset, asynchronous, active-low.
- `in_empty` in 1: plaintext FIFO empty.
- `in_r_data` in 8: plaintext FIFO head byte, valid while `in_empty`=0.
- `in_r_enable` out 1: pop request; the head byte is consumed at the next edge.
- `flush` in 1: level request to close a partial block.
- `aes_start` out 1: one-cycle launch pulse.
- `aes_plaintext` out 128: block to encrypt; stable from LAUNCH until `aes_done`.
- `aes_done` in 1: one-cycle completion pulse from the core.
- `aes_ciphertext` in 128: result, valid in the cycle `aes_done`=1.
- `out_ready` in 1: output serializer idle and its FIFO empty.
- `out_complete` out 1: one-cycle handoff pulse (drives the serializer's `complete`).
- `out_block` out 128: ciphertext, valid while `out_complete`=1.
- `busy` out 1: state is not IDLE.
- `error` out 1: sticky AES timeout flag.
- `blocks_done` out CNT_W: count of emitted blocks; wraps at 2^CNT_W.

## Operation
- The byte order is MSB-first: the first byte popped lands in [127:120] and the 16th in [7:0].
- States:
  - IDLE: byte count is 0. `in_empty`=0 moves to GATHER.
  - GATHER: `in_r_enable` = !`in_empty`. Each pop stores the byte at slot `count` and increments `count`. The pop that brings `count` to 16 moves to LAUNCH.
  - LAUNCH: `aes_start`=1 for exactly one cycle, then WAIT_AES.
  - WAIT_AES: `aes_done`=1 captures `aes_ciphertext` into the result register and moves to HOLD. If the cycle counter reaches TIMEOUT_CYCLES, move to ERROR.
  - HOLD: waits for `out_ready`=1, then EMIT.
  - EMIT: `out_complete`=1 for one cycle and `blocks_done` increments. `count` clears. Next state is GATHER if `in_empty`=0, otherwise IDLE.
  - ERROR: `error`=1, all handshake outputs are 0, no pops occur. Only reset exits this state.
- `in_r_enable` is 0 in every state other than GATHER, so input stalls while a block is in flight.
- `aes_done` outside WAIT_AES is ignored.
- `out_ready` is sampled only in HOLD.
- `flush` is honored only in GATHER with `in_empty`=1 and 0 < `count` < 16. It is ignored in every other case, including `count`=0 and any state other than GATHER.
- When `in_empty`=0 in the same cycle as `flush`, gathering takes priority and `flush` is re-evaluated on later cycles.

## Timing
- Reset values:
  - State IDLE, `count` 0, `blocks_done` 0.
  - `in_r_enable`, `aes_start`, `out_complete`, `busy`, `error` all 0.
  - `aes_plaintext` and `out_block` all zeros.
- Reset mid-operation aborts the block: any partial block or captured ciphertext is discarded.
- With a continuously non-empty FIFO, GATHER lasts 16 cycles. The pop of byte 16 is followed by LAUNCH on the next cycle.
- Latency from the last pop to `out_complete` is 1 (LAUNCH) + AES latency + 1 (capture) + HOLD cycles. With `out_ready` already high, HOLD lasts one cycle.
- The timeout counter clears on entry to WAIT_AES. ERROR is entered on the edge where the count equals TIMEOUT_CYCLES. An `aes_done` in that same cycle wins and the block proceeds to HOLD.
- `blocks_done` wraps from 2^CNT_W−1 to 0.

## Configuration
- The feature is controlled by the macro `AES_SCHED_PAD_EN`.
- When `AES_SCHED_PAD_EN` is defined, an honored flush zero-fills slots `count`..15 and moves to LAUNCH. The padded block is encrypted and emitted normally.
- When `AES_SCHED_PAD_EN` is not defined, an honored flush discards the partial bytes, clears `count` and moves to IDLE. Nothing is launched and `blocks_done` is unchanged.

## Structure
- The package `aes_sched_pkg` holds:
  - the state enum `sched_state_t`;
  - `BLOCK_BYTES`=16;
  - `BLOCK_W`=128;
  - `BYTE_W`=8.
- The sub-module `aes_block_gather` contains the byte-slot register, the 5-bit count, the `full16` flag, and the clear and zero-pad controls. The FSM, the timeout counter and the result register live in the top module.

## Test plan
- Push bytes 0x00..0x0F, AES model done after 10 cycles returning plaintext XOR 0xFF.., `out_ready`=1. Required: `aes_plaintext`=0x000102..0F, exactly one `out_complete` with `out_block`=0xFFFEFD..F0, and `blocks_done`=1.
- Push 32 bytes back-to-back. Required: two launches, with no pop while state ≠ GATHER and `blocks_done`=2.
- Hold `out_ready`=0 for 50 cycles after `aes_done`. Required: state stays HOLD, `out_block` does not change, `in_r_enable`=0, and `out_complete` fires one cycle after `out_ready` rises.
- Push 5 bytes 0xA1..0xA5, then raise `flush`.
  - With `AES_SCHED_PAD_EN`: `aes_plaintext`=0xA1A2A3A4A5 followed by 11 zero bytes.
  - Without it: `aes_start` is never asserted, and IDLE is reached with `count`=0.
- Hold `aes_done` low. Required: `error`=1 after 64 WAIT_AES cycles and no further pops. Reset then clears `error` and the state returns to IDLE.
- Assert `n_rst`=0 mid-GATHER with 7 bytes collected. Required: all outputs reset immediately, and the next 16 bytes form a fresh block.
